// File: rtl/bbox_stats_writer.sv
// Per-colour bounding box and pixel count over a raster pixel stream, flushed to a
// word memory at end of frame. Define BBOX_FRAME_COUNTER_EN to append a frame-count word.
module bbox_stats_writer #(
    parameter int IMAGE_W     = 640,
    parameter int IMAGE_H     = 480,
    parameter int NUM_COLOURS = 4,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic                   st_sop,
    input  logic                   st_eop,
    input  logic [NUM_COLOURS-1:0] st_mask,
    output logic                   st_ready,
    output logic [7:0]             mem_address,
    output logic                   mem_chipselect,
    output logic                   mem_write,
    output logic [3:0]             mem_byteenable,
    output logic [31:0]            mem_writedata,
    output logic                   frame_done,
    output logic                   sync_err
);

`ifdef BBOX_FRAME_COUNTER_EN
    localparam int NUM_WORDS = 3 * NUM_COLOURS + 1;
`else
    localparam int NUM_WORDS = 3 * NUM_COLOURS;
`endif
    localparam logic [7:0]  BASE      = 8'(BASE_ADDR);
    localparam logic [7:0]  LAST_WORD = 8'(NUM_WORDS - 1);
    localparam logic [15:0] X_LAST    = 16'(IMAGE_W - 1);
    localparam logic [15:0] Y_LAST    = 16'(IMAGE_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] x_reg, y_reg;
    logic [7:0]  word_reg;
    logic [3:0]  colour_reg;
    logic [1:0]  sel_reg;
    logic        frame_done_reg;
    logic        sync_err_reg;

    logic        beat, start, pix, last_word;
    logic [15:0] px, py;

    logic [31:0] box_lo   [NUM_COLOURS];
    logic [31:0] box_hi   [NUM_COLOURS];
    logic [31:0] cnt_word [NUM_COLOURS];

    // A start-of-frame beat is taken at (0,0) regardless of where the counters are.
    assign beat      = st_valid && st_ready;
    assign start     = beat && st_sop;
    assign pix       = start || (beat && (state_reg == ACCUM));
    assign px        = start ? 16'd0 : x_reg;
    assign py        = start ? 16'd0 : y_reg;
    assign last_word = (state_reg == FLUSH) && (word_reg == LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = st_eop ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (pix && st_eop) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        st_ready       = 1'b1;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'b1111;
        mem_address    = BASE + word_reg;
        if (state_reg == FLUSH) begin
            st_ready       = 1'b0;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= 16'd0;
            y_reg <= 16'd0;
        end else if (pix) begin
            if (px == X_LAST) begin
                x_reg <= 16'd0;
                y_reg <= (py == Y_LAST) ? py : py + 16'd1;
            end else begin
                x_reg <= px + 16'd1;
                y_reg <= py;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_COLOURS; gi++) begin : g_colour
        logic [15:0] min_x_reg, min_y_reg, max_x_reg, max_y_reg;
        logic [31:0] count_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                min_x_reg <= 16'hFFFF;
                min_y_reg <= 16'hFFFF;
                max_x_reg <= 16'd0;
                max_y_reg <= 16'd0;
                count_reg <= 32'd0;
            end else if (start) begin
                // Clear and fold in the (0,0) pixel in one step.
                min_x_reg <= st_mask[gi] ? 16'd0 : 16'hFFFF;
                min_y_reg <= st_mask[gi] ? 16'd0 : 16'hFFFF;
                max_x_reg <= 16'd0;
                max_y_reg <= 16'd0;
                count_reg <= st_mask[gi] ? 32'd1 : 32'd0;
            end else if (pix && st_mask[gi]) begin
                if (px < min_x_reg) min_x_reg <= px;
                if (py < min_y_reg) min_y_reg <= py;
                if (px > max_x_reg) max_x_reg <= px;
                if (py > max_y_reg) max_y_reg <= py;
                if (count_reg != 32'hFFFF_FFFF) count_reg <= count_reg + 32'd1;
            end
        end

        // Empty colours read back as FFFF_FFFF / 0 / 0 straight from the cleared values.
        assign box_lo[gi]   = {min_y_reg, min_x_reg};
        assign box_hi[gi]   = {max_y_reg, max_x_reg};
        assign cnt_word[gi] = count_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || (state_reg != FLUSH) || last_word) begin
            word_reg   <= 8'd0;
            colour_reg <= 4'd0;
            sel_reg    <= 2'd0;
        end else begin
            word_reg <= word_reg + 8'd1;
            if (sel_reg == 2'd2) begin
                sel_reg    <= 2'd0;
                colour_reg <= colour_reg + 4'd1;
            end else begin
                sel_reg <= sel_reg + 2'd1;
            end
        end
    end

`ifdef BBOX_FRAME_COUNTER_EN
    logic [31:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= 32'd0;
        end else if (last_word) begin
            frame_cnt_reg <= frame_cnt_reg + 32'd1;
        end
    end
`endif

    always_comb begin
        mem_writedata = 32'd0;
        for (int k = 0; k < NUM_COLOURS; k++) begin
            if (colour_reg == 4'(k)) begin
                case (sel_reg)
                    2'd0:    mem_writedata = box_lo[k];
                    2'd1:    mem_writedata = box_hi[k];
                    default: mem_writedata = cnt_word[k];
                endcase
            end
        end
`ifdef BBOX_FRAME_COUNTER_EN
        // The count word includes the frame being flushed right now.
        if (colour_reg == 4'(NUM_COLOURS)) begin
            mem_writedata = frame_cnt_reg + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            frame_done_reg <= last_word;
            sync_err_reg   <= start && (state_reg == ACCUM);
        end
    end

    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_bbox_stats_writer.sv
// Self-checking bench for bbox_stats_writer: directed and random frames against a
// pixel-index reference model; honours BBOX_FRAME_COUNTER_EN when defined.
module tb_bbox_stats_writer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NC   = 2;
    localparam int BASE = 16;
`ifdef BBOX_FRAME_COUNTER_EN
    localparam int NW = 3 * NC + 1;
`else
    localparam int NW = 3 * NC;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid, st_sop, st_eop;
    logic [NC-1:0] st_mask;
    logic          st_ready;
    logic [7:0]    mem_address;
    logic          mem_chipselect, mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic          frame_done, sync_err;

    bbox_stats_writer #(
        .IMAGE_W(W), .IMAGE_H(H), .NUM_COLOURS(NC), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_mask(st_mask),
        .st_ready(st_ready),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            frames_model = 0;
    logic [NC-1:0] frame_masks[$];
    logic [31:0]   exp_words[$];
    logic [31:0]   cap_words[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] capv(input int i);
        if (i < cap_words.size()) return cap_words[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Beat i of a frame sits at raster position (i mod W, i div W) with y clamped to H-1.
    function automatic void build_expected();
        int         mnx[NC], mny[NC], mxx[NC], mxy[NC];
        bit  [31:0] cnt[NC];
        exp_words.delete();
        for (int k = 0; k < NC; k++) begin
            mnx[k] = 65535; mny[k] = 65535; mxx[k] = 0; mxy[k] = 0; cnt[k] = 0;
        end
        for (int i = 0; i < frame_masks.size(); i++) begin
            int x, y;
            x = i % W;
            y = i / W;
            if (y > H - 1) y = H - 1;
            for (int k = 0; k < NC; k++) begin
                if (frame_masks[i][k]) begin
                    if (x < mnx[k]) mnx[k] = x;
                    if (y < mny[k]) mny[k] = y;
                    if (x > mxx[k]) mxx[k] = x;
                    if (y > mxy[k]) mxy[k] = y;
                    if (cnt[k] != 32'hFFFF_FFFF) cnt[k] = cnt[k] + 1;
                end
            end
        end
        for (int k = 0; k < NC; k++) begin
            exp_words.push_back({mny[k][15:0], mnx[k][15:0]});
            exp_words.push_back({mxy[k][15:0], mxx[k][15:0]});
            exp_words.push_back(cnt[k]);
        end
`ifdef BBOX_FRAME_COUNTER_EN
        exp_words.push_back(32'(frames_model + 1));
`endif
    endfunction

    task automatic drive_beats(input bit sop_first, input bit eop_last, input bit gaps,
                               output logic se_first, output int wr_seen);
        int n;
        n = frame_masks.size();
        wr_seen  = 0;
        se_first = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                while ($urandom_range(0, 3) == 0) begin
                    st_valid = 1'b0;
                    st_sop   = 1'($urandom);
                    st_eop   = 1'($urandom);
                    st_mask  = NC'($urandom);
                    step();
                    if (mem_write) wr_seen++;
                end
            end
            st_valid = 1'b1;
            st_sop   = sop_first && (i == 0);
            st_eop   = eop_last && (i == n - 1);
            st_mask  = frame_masks[i];
            step();
            if (i == 0) se_first = sync_err;
            if (mem_write && !(eop_last && i == n - 1)) wr_seen++;
        end
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_mask = '0;
    endtask

    // Called one cycle after the eop beat was taken; returns in the first IDLE cycle.
    task automatic flush_and_check(input string tag, input bit hold_valid);
        build_expected();
        cap_words.delete();
        for (int c = 0; c <= NW; c++) begin
            if (hold_valid && c < NW) begin
                st_valid = 1'b1;
                st_sop   = 1'($urandom);
                st_mask  = NC'($urandom);
            end else begin
                st_valid = 1'b0; st_sop = 1'b0; st_mask = '0;
            end
            chk({tag, " write"}, mem_write, (c < NW));
            chk({tag, " cs"}, mem_chipselect, (c < NW));
            chk({tag, " ready"}, st_ready, (c == NW));
            chk({tag, " done"}, frame_done, (c == NW));
            if (c < NW) begin
                chk({tag, " addr"}, mem_address, 8'(BASE + c));
                chk({tag, " data"}, mem_writedata, exp_words[c]);
                chk({tag, " be"}, mem_byteenable, 4'hF);
                cap_words.push_back(mem_writedata);
                step();
            end
        end
        frames_model++;
        $display("frame %s: beats=%0d words=%0d frames=%0d", tag, frame_masks.size(), NW, frames_model);
    endtask

    initial begin
        logic se;
        int   wr;
        reset = 1'b1; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_mask = '0;
        repeat (3) step();
        chk("rst write", mem_write, 1'b0);
        chk("rst cs", mem_chipselect, 1'b0);
        chk("rst done", frame_done, 1'b0);
        chk("rst syncerr", sync_err, 1'b0);
        reset = 1'b0;
        step();
        chk("rst ready", st_ready, 1'b1);

        // Known frame: colour 0 at (2,1) and (5,3), colour 1 never.
        frame_masks.delete();
        for (int i = 0; i < W * H; i++) frame_masks.push_back('0);
        frame_masks[1 * W + 2] = 2'b01;
        frame_masks[3 * W + 5] = 2'b01;
        drive_beats(1'b1, 1'b1, 1'b0, se, wr);
        chk("full syncerr", se, 1'b0);
        chk("full early wr", wr, 0);
        flush_and_check("full", 1'b0);
        chk("full w16", capv(0), 32'h0001_0002);
        chk("full w17", capv(1), 32'h0003_0005);
        chk("full w18", capv(2), 32'd2);
        chk("full w19", capv(3), 32'hFFFF_FFFF);
        chk("full w20", capv(4), 32'd0);
        chk("full w21", capv(5), 32'd0);
`ifdef BBOX_FRAME_COUNTER_EN
        chk("full w22", capv(6), 32'd1);
`endif

        // One-pixel frame.
        frame_masks.delete();
        frame_masks.push_back(2'b11);
        drive_beats(1'b1, 1'b1, 1'b0, se, wr);
        flush_and_check("single", 1'b0);
        chk("single w18", capv(2), 32'd1);
        chk("single w21", capv(5), 32'd1);

        // Random frames, some with junk IDLE beats, gaps and valid held during flush.
        for (int f = 0; f < 8; f++) begin
            int len;
            int junk;
            junk = $urandom_range(0, 3);
            for (int j = 0; j < junk; j++) begin
                st_valid = 1'b1; st_sop = 1'b0; st_eop = 1'($urandom); st_mask = NC'($urandom);
                step();
            end
            st_valid = 1'b0; st_eop = 1'b0;
            chk("idle junk ready", st_ready, 1'b1);
            len = $urandom_range(1, 40);
            frame_masks.delete();
            for (int i = 0; i < len; i++) begin
                frame_masks.push_back(($urandom_range(0, 3) == 0) ? NC'($urandom) : '0);
            end
            drive_beats(1'b1, 1'b1, 1'(f % 2), se, wr);
            chk("rand syncerr", se, 1'b0);
            chk("rand early wr", wr, 0);
            flush_and_check($sformatf("rand%0d", f), 1'(f >= 4));
        end

        // Restart in ACCUM after 10 beats: only the second frame is reported.
        frame_masks.delete();
        for (int i = 0; i < 10; i++) frame_masks.push_back(2'b11);
        drive_beats(1'b1, 1'b0, 1'b0, se, wr);
        frame_masks.delete();
        for (int i = 0; i < 20; i++) frame_masks.push_back((i == 12) ? 2'b10 : 2'b00);
        drive_beats(1'b1, 1'b1, 1'b0, se, wr);
        chk("restart syncerr", se, 1'b1);
        chk("restart no writes", wr, 0);
        flush_and_check("restart", 1'b0);

        // Reset on the third flush cycle.
        frame_masks.delete();
        for (int i = 0; i < 5; i++) frame_masks.push_back(2'b01);
        drive_beats(1'b1, 1'b1, 1'b0, se, wr);
        chk("abort w16 addr", mem_address, 8'(BASE));
        step();
        step();
        chk("abort third write", mem_write, 1'b1);
        reset = 1'b1;
        step();
        chk("abort write", mem_write, 1'b0);
        chk("abort cs", mem_chipselect, 1'b0);
        chk("abort done", frame_done, 1'b0);
        reset = 1'b0;
        frames_model = 0;
        step();
        chk("abort write after", mem_write, 1'b0);
        chk("abort ready", st_ready, 1'b1);

        // Two back-to-back frames after the reset.
        for (int f = 0; f < 2; f++) begin
            frame_masks.delete();
            for (int i = 0; i < 6 + f; i++) frame_masks.push_back(NC'($urandom));
            drive_beats(1'b1, 1'b1, 1'b0, se, wr);
            flush_and_check($sformatf("b2b%0d", f), 1'b0);
`ifdef BBOX_FRAME_COUNTER_EN
            chk("b2b frame count", capv(NW - 1), 32'(f + 1));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
